// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader_pkg
// Description : Shared state encodings and framing constants for the
//               instruction-memory boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_loader_pkg;

    // Loader FSM encodings
    localparam logic [1:0] ST_LEN   = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Stream framing: 2-byte big-endian length header, 4-byte big-endian words
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;

    // Terminal values of the byte counters
    localparam logic [1:0] BYTE_CNT_LAST = 2'(BYTES_PER_WORD - 1);
    localparam logic       LEN_CNT_LAST  = 1'(LEN_BYTES - 1);

    // Default instruction memory depth in words, shared with the memory
    localparam int unsigned DEF_TAMANHO_MEMORIA = 64;

endpackage
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : imem_word_assembler
// Description : Shifts accepted boot bytes into a big-endian 32-bit word and
//               flags the byte that completes each word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;

    // Collect the first three bytes of a word; the fourth is combined directly
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_en) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // The completing byte is appended combinationally so the word is ready
    // on the same cycle as its last handshake.
    assign o_word_valid = i_en && (r_byte_cnt == BYTE_CNT_LAST);
    assign o_word       = {r_shift, i_byte};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Boot-time loader for the instruction memory. Receives a
//               length-prefixed byte stream, writes assembled words into the
//               memory, owns the memory address mux and stalls the CPU until
//               the program is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned TAMANHO_MEMORIA = DEF_TAMANHO_MEMORIA,
    parameter int unsigned AW              = $clog2(TAMANHO_MEMORIA)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          boot_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   mem_addr,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err
);

    logic [1:0]    r_state;
    logic          r_len_cnt;
    logic [15:0]   r_len;
    logic [15:0]   r_word_cnt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_waddr;
    logic [31:0]   r_mem_wdata;
    logic          r_load_err;

    logic          w_xfer;
    logic          w_asm_en;
    logic          w_restart;
    logic [15:0]   w_len_next;
    logic          w_len_over;
    logic          w_in_range;
    logic          w_last_word;
    logic          w_word_valid;
    logic [31:0]   w_word;

    assign w_xfer      = in_valid && in_ready;
    assign w_asm_en    = w_xfer && (r_state == ST_LOAD);
    assign w_restart   = (r_state == ST_DONE) && boot_start;
    assign w_len_next  = {r_len[7:0], in_data};
    assign w_len_over  = {16'd0, w_len_next} > TAMANHO_MEMORIA;
    // Words beyond the memory depth are still consumed to keep framing
    assign w_in_range  = {16'd0, r_word_cnt} < TAMANHO_MEMORIA;
    assign w_last_word = (r_word_cnt == (r_len - 16'd1));

    imem_word_assembler u_asm (
        .clk          (clock),
        .rst          (reset),
        .i_clr        (w_restart),
        .i_en         (w_asm_en),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Loader FSM, counters and the registered write port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_LEN;
            r_len_cnt   <= 1'b0;
            r_len       <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'd0;
            r_load_err  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_LEN: begin
                    if (w_xfer) begin
                        r_len <= w_len_next;
                        if (r_len_cnt == LEN_CNT_LAST) begin
                            r_len_cnt <= 1'b0;
                            if (w_len_over) begin
                                r_load_err <= 1'b1;
                            end
                            r_state <= (w_len_next == 16'd0) ? ST_DONE : ST_LOAD;
                        end else begin
                            r_len_cnt <= r_len_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_valid) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                        if (w_in_range) begin
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= r_word_cnt[AW-1:0];
                            r_mem_wdata <= w_word;
                        end
                        if (w_last_word) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (boot_start) begin
                        r_state    <= ST_LEN;
                        r_len_cnt  <= 1'b0;
                        r_len      <= 16'd0;
                        r_word_cnt <= 16'd0;
                        r_load_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LEN;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_LEN) || (r_state == ST_LOAD);
    assign cpu_hold  = (r_state != ST_DONE);
    assign load_done = (r_state == ST_DONE);
    assign load_err  = r_load_err;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    // The CPU only fetches once loading is finished, so the mux can follow
    // cpu_hold directly.
    assign mem_addr  = cpu_hold ? {14'd0, r_word_cnt, 2'b00} : pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench. Two loaders (64-word and 4-word memory)
//               receive the same stream; expected writes are derived from the
//               stream framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        boot_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [31:0] pc;

    logic        in_ready_a, in_ready_b;
    logic [31:0] mem_addr_a, mem_addr_b;
    logic        mem_we_a, mem_we_b;
    logic [5:0]  mem_waddr_a;
    logic [1:0]  mem_waddr_b;
    logic [31:0] mem_wdata_a, mem_wdata_b;
    logic        cpu_hold_a, cpu_hold_b;
    logic        load_done_a, load_done_b;
    logic        load_err_a, load_err_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq_a[$];
    wr_t         wq_b[$];
    logic [7:0]  stim[$];

    always #5 clock = ~clock;

    imem_boot_loader #(.TAMANHO_MEMORIA(64)) u_dut_a (
        .clock(clock), .reset(reset), .boot_start(boot_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .pc(pc), .mem_addr(mem_addr_a), .mem_we(mem_we_a),
        .mem_waddr(mem_waddr_a), .mem_wdata(mem_wdata_a),
        .cpu_hold(cpu_hold_a), .load_done(load_done_a), .load_err(load_err_a)
    );

    imem_boot_loader #(.TAMANHO_MEMORIA(4)) u_dut_b (
        .clock(clock), .reset(reset), .boot_start(boot_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .pc(pc), .mem_addr(mem_addr_b), .mem_we(mem_we_b),
        .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .cpu_hold(cpu_hold_b), .load_done(load_done_b), .load_err(load_err_b)
    );

    // Write-port monitors
    always @(negedge clock) begin
        if (mem_we_a) wq_a.push_back('{int'(mem_waddr_a), mem_wdata_a});
        if (mem_we_b) wq_b.push_back('{int'(mem_waddr_b), mem_wdata_b});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    // Offer one byte, wait for the handshake, then idle for gap cycles
    task automatic send(input logic [7:0] b, input int gap, input logic bs);
        int t = 0;
        in_valid   = 1'b1;
        in_data    = b;
        boot_start = bs;
        while (!in_ready_a && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("ready_timeout", 64'(t < 50), 64'(1));
        chk("ready_match", 64'(in_ready_b), 64'(in_ready_a));
        @(negedge clock);
        in_valid   = 1'b0;
        boot_start = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic restart();
        boot_start = 1'b1;
        @(negedge clock);
        boot_start = 1'b0;
        chk("restart_hold", 64'(cpu_hold_a), 64'(1));
        chk("restart_done", 64'(load_done_a), 64'(0));
        chk("restart_err", 64'(load_err_b), 64'(0));
    endtask

    // Stream a length header plus stim[] and check the complete load
    task automatic run_load(input int len, input int gap_mode, input int bs_at);
        int base_a = wq_a.size();
        int base_b = wq_b.size();
        int n_a    = (len < 64) ? len : 64;
        int n_b    = (len < 4)  ? len : 4;
        int t      = 0;
        logic [15:0] l16 = 16'(len);
        logic [31:0] w;
        logic [31:0] pcv;
        chk("len_addr", 64'(mem_addr_a), 64'(0));
        send(l16[15:8], pick_gap(gap_mode), 1'b0);
        chk("len_hold", 64'(cpu_hold_a), 64'(1));
        send(l16[7:0], pick_gap(gap_mode), 1'b0);
        if (len == 0) begin
            chk("len0_done_now", 64'(load_done_a), 64'(1));
        end
        for (int j = 0; j < len * 4; j++) begin
            chk("load_hold_b", 64'(cpu_hold_b), 64'(1));
            chk("load_addr_a", 64'(mem_addr_a), 64'((j / 4) * 4));
            chk("load_addr_b", 64'(mem_addr_b), 64'((j / 4) * 4));
            send(stim[j], pick_gap(gap_mode), 1'(j == bs_at));
        end
        while (!load_done_a && t < 10) begin
            @(negedge clock);
            t++;
        end
        chk("done_a", 64'(load_done_a), 64'(1));
        chk("done_b", 64'(load_done_b), 64'(1));
        chk("hold_released", 64'(cpu_hold_a), 64'(0));
        chk("err_a", 64'(load_err_a), 64'(len > 64));
        chk("err_b", 64'(load_err_b), 64'(len > 4));
        chk("we_idle", 64'(mem_we_a | mem_we_b), 64'(0));
        chk("wr_count_a", 64'(wq_a.size() - base_a), 64'(n_a));
        chk("wr_count_b", 64'(wq_b.size() - base_b), 64'(n_b));
        for (int k = 0; k < n_a && base_a + k < wq_a.size(); k++) begin
            w = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
            chk("wr_addr_a", 64'(wq_a[base_a+k].addr), 64'(k));
            chk("wr_data_a", 64'(wq_a[base_a+k].data), 64'(w));
        end
        for (int k = 0; k < n_b && base_b + k < wq_b.size(); k++) begin
            w = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
            chk("wr_addr_b", 64'(wq_b[base_b+k].addr), 64'(k));
            chk("wr_data_b", 64'(wq_b[base_b+k].data), 64'(w));
        end
        pcv = $urandom & 32'hFFFF_FFFC;
        pc  = pcv;
        #1;
        chk("pc_mux_a", 64'(mem_addr_a), 64'(pcv));
        chk("pc_mux_b", 64'(mem_addr_b), 64'(pcv));
        @(negedge clock);
    endtask

    task automatic fill_random(input int len);
        stim = {};
        for (int i = 0; i < len * 4; i++) stim.push_back(8'($urandom));
    endtask

    initial begin
        int base_a, base_b;
        reset      = 1'b1;
        boot_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        pc         = 32'd0;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_hold", 64'(cpu_hold_a), 64'(1));
        chk("rst_done", 64'(load_done_a), 64'(0));
        chk("rst_err", 64'(load_err_a), 64'(0));
        chk("rst_we", 64'(mem_we_a), 64'(0));
        chk("rst_waddr", 64'(mem_waddr_a), 64'(0));
        chk("rst_wdata", 64'(mem_wdata_a), 64'(0));
        chk("rst_ready", 64'(in_ready_a), 64'(1));
        chk("rst_addr", 64'(mem_addr_a), 64'(0));
        reset = 1'b0;

        // Two-word program straight after reset
        stim = {};
        push_word(32'h2008_0005);
        push_word(32'h0000_0008);
        run_load(2, 0, -1);
        pc = 32'h4;
        #1;
        chk("pc4_addr", 64'(mem_addr_a), 64'(32'h4));
        @(negedge clock);

        // Empty program
        restart();
        stim = {};
        run_load(0, 0, -1);

        // Program longer than the small memory
        restart();
        fill_random(6);
        run_load(6, 0, -1);

        // Same two-word program with a gap after every byte
        restart();
        stim = {};
        push_word(32'h2008_0005);
        push_word(32'h0000_0008);
        run_load(2, 1, -1);

        // Reset in the middle of the second word
        restart();
        base_a = wq_a.size();
        base_b = wq_b.size();
        send(8'h00, 0, 1'b0);
        send(8'h02, 0, 1'b0);
        send(8'h11, 0, 1'b0);
        send(8'h22, 0, 1'b0);
        send(8'h33, 0, 1'b0);
        send(8'h44, 0, 1'b0);
        send(8'h55, 0, 1'b0);
        send(8'h66, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_hold", 64'(cpu_hold_a), 64'(1));
        chk("midrst_done", 64'(load_done_a), 64'(0));
        chk("midrst_ready", 64'(in_ready_a), 64'(1));
        chk("midrst_addr", 64'(mem_addr_a), 64'(0));
        repeat (3) @(negedge clock);
        chk("midrst_wr_a", 64'(wq_a.size() - base_a), 64'(1));
        chk("midrst_wr_b", 64'(wq_b.size() - base_b), 64'(1));
        if (wq_a.size() > base_a) begin
            chk("midrst_word", 64'(wq_a[base_a].data), 64'(32'h1122_3344));
        end
        fill_random(3);
        run_load(3, 2, -1);

        // Restart with boot_start pulsed while loading
        restart();
        stim = {};
        push_word(32'hDEAD_BEEF);
        run_load(1, 0, 2);

        // Random programs with random gaps
        for (int it = 0; it < 4; it++) begin
            int len = int'($urandom_range(0, 7));
            restart();
            fill_random(len);
            run_load(len, 2, int'($urandom_range(0, 8)));
        end

        // Bytes offered while not ready are ignored
        base_a = wq_a.size();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clock);
        chk("nr_ready", 64'(in_ready_a), 64'(0));
        chk("nr_done", 64'(load_done_a), 64'(1));
        chk("nr_writes", 64'(wq_a.size() - base_a), 64'(0));
        in_valid = 1'b0;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot-time controller for the instruction memory (ROM array, 32-bit words, byte address >> 2 indexing, asynchronous read).
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the instruction memory through a write port.
- Owns the memory address mux: loader address while loading, CPU PC afterwards.
- Holds the CPU stalled until the program is fully loaded. Sits between the boot interface, the PC register and the instruction memory.

Parameters:
TAMANHO_MEMORIA, 64, instruction memory depth in 32-bit words (power of two, >= 4).
AW, $clog2(TAMANHO_MEMORIA), word-index width (derived, do not override).

Ports:
clock  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
boot_start  input  1  one-cycle pulse; restarts loading, honoured only in DONE.
in_valid  input  1  boot byte valid.
in_data  input  8  boot byte.
in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready.
pc  input  32  CPU program counter (byte address).
mem_addr  output  32  byte address driven to the instruction memory read port.
mem_we  output  1  instruction memory write enable, one cycle per word.
mem_waddr  output  AW  word index for write.
mem_wdata  output  32  word to write.
cpu_hold  output  1  stalls PC/CPU while high.
load_done  output  1  high in DONE.
load_err  output  1  sticky: program length exceeded TAMANHO_MEMORIA.

Behaviour:
- Reset: state=LEN, byte_cnt=0, word_cnt=0, len=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0. Loading starts automatically after reset. Reset mid-load abandons the partial word; memory contents already written are left untouched.
- States: LEN, LOAD, FLUSH, DONE.
- in_ready = 1 in LEN and LOAD; 0 in FLUSH and DONE.
- LEN: accepts 2 bytes, MSB first, forming a 16-bit len (word count).
  - After the 2nd byte: len==0 -> DONE; else -> LOAD.
  - len > TAMANHO_MEMORIA -> load_err=1, still proceeds to LOAD.
- LOAD: bytes shift into a 32-bit word, first byte becomes [31:24]; byte_cnt wraps 0..3.
  - On the 4th accepted byte: next cycle mem_we=1, mem_wdata=word, mem_waddr=word_cnt[AW-1:0]; then word_cnt++.
  - Words with word_cnt >= TAMANHO_MEMORIA are consumed but not written (mem_we stays 0), so the stream stays in sync.
  - When the last word (word_cnt==len-1) is accepted -> FLUSH.
- FLUSH: the final write pulse is issued this cycle -> DONE next cycle.
- DONE: cpu_hold=0, load_done=1, mem_we=0.
  - boot_start -> LEN, cpu_hold=1, load_done=0, load_err=0, counters cleared.
  - boot_start outside DONE is ignored.
- mem_we is a single-cycle registered pulse. A new word cannot complete before 4 more handshakes, so there is no write/assemble conflict.
- mem_addr = cpu_hold ? {word_cnt[29:0],2'b00} : pc. This is combinational: the CPU fetches only after DONE.
- in_valid while in_ready=0: byte is not consumed; the source must hold it.
- Gaps in in_valid at any byte position: state and partial word hold.

Decomposition:
- Shared package/header: state encodings (ST_LEN, ST_LOAD, ST_FLUSH, ST_DONE, 2 bits) and constants BYTES_PER_WORD=4, LEN_BYTES=2. TAMANHO_MEMORIA default shared with the instruction memory.
- One natural sub-module: imem_word_assembler (byte shift register + byte_cnt, emits word_valid pulse and word). FSM, counters and address mux stay in imem_boot_loader.
- The instruction memory gains a synchronous write port (we, waddr, wdata) driven by this block.

Test Plan:
- Reset then stream 00 02 | 20 08 00 05 | 00 00 00 08 -> mem_we pulses at waddr 0 (0x20080005) and 1 (0x00000008). load_done=1, cpu_hold=0, mem_addr follows pc=0x4.
- Stream 00 00 -> DONE within 1 cycle of the 2nd byte, no mem_we, load_err=0.
- TAMANHO_MEMORIA=4, len=6, 24 data bytes -> exactly 4 writes (waddr 0..3), load_err=1, all 24 bytes accepted, DONE reached.
- in_valid toggling 1/0 every cycle during LOAD -> identical memory writes to the contiguous case, just slower.
- Assert reset after 2 of 4 bytes of word 1 -> state LEN, cpu_hold=1, no write for the partial word. A fresh stream loads correctly.
- In DONE, pulse boot_start, stream 00 01 | DE AD BE EF -> cpu_hold 1 during load, write 0xDEADBEEF at waddr 0, load_done returns to 1. boot_start pulsed during LOAD has no effect.
